comparator_threshold_monitor: RTL and testbench

COMPARATOR_THRESHOLD_MONITOR -- requirements
Module: comparator_threshold_monitor

---
 rtl/comparator_threshold_monitor_pkg.sv | 34 +++
 rtl/comparator_threshold_monitor_cmp_core.sv | 42 ++++
 rtl/comparator_threshold_monitor.sv | 176 +++++++++++++++++
 tb/tb_comparator_threshold_monitor.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/comparator_threshold_monitor_pkg.sv
// Shared types for the threshold monitor: compare modes and debounce FSM states.
// The alarm level of each state is derived here so the top never hard-codes it.
package comparator_threshold_monitor_pkg;

    typedef enum logic [2:0] {
        CMP_GT   = 3'd0,
        CMP_GE   = 3'd1,
        CMP_LT   = 3'd2,
        CMP_LE   = 3'd3,
        CMP_EQ   = 3'd4,
        CMP_NE   = 3'd5,
        CMP_RSV6 = 3'd6,
        CMP_RSV7 = 3'd7
    } cmp_mode_e;

    typedef enum logic [1:0] {
        MON_IDLE      = 2'd0,
        MON_ARMING    = 2'd1,
        MON_ACTIVE    = 2'd2,
        MON_DISARMING = 2'd3
    } mon_state_e;

    // ACTIVE and DISARMING both hold the alarm high.
    function automatic logic state_alarm(input mon_state_e st);
        logic alarm_s;
        case (st)
            MON_ACTIVE:    alarm_s = 1'b1;
            MON_DISARMING: alarm_s = 1'b1;
            default:       alarm_s = 1'b0;
        endcase
        return alarm_s;
    endfunction

endpackage

// File: rtl/comparator_threshold_monitor_cmp_core.sv
// Combinational A-op-B comparator. Signed compare is done by flipping the sign
// bit of both operands, which maps two's-complement order onto unsigned order.
module cmp_core
    import comparator_threshold_monitor_pkg::*;
#(
    parameter int DATA_WIDTH = 13,
    parameter int SIGNED_CMP = 0
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  cmp_mode_e             mode,
    output logic                  result
);

    localparam logic SIGN_BIT = (SIGNED_CMP != 32'sd0);
    localparam logic [DATA_WIDTH-1:0] SIGN_FLIP = {SIGN_BIT, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-1:0] a_key_s;
    logic [DATA_WIDTH-1:0] b_key_s;
    logic                  gt_s;
    logic                  eq_s;

    assign a_key_s = a ^ SIGN_FLIP;
    assign b_key_s = b ^ SIGN_FLIP;
    assign gt_s    = (a_key_s > b_key_s);
    assign eq_s    = (a_key_s == b_key_s);

    // Mode decode; reserved modes always report false.
    always_comb begin
        result = 1'b0;
        case (mode)
            CMP_GT:  result = gt_s;
            CMP_GE:  result = gt_s | eq_s;
            CMP_LT:  result = ~(gt_s | eq_s);
            CMP_LE:  result = ~gt_s;
            CMP_EQ:  result = eq_s;
            CMP_NE:  result = ~eq_s;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/comparator_threshold_monitor.sv
// Threshold monitor: registered compare of each accepted sample against a
// loadable threshold, followed by a debounce FSM driving a glitch-free alarm.
module comparator_threshold_monitor
    import comparator_threshold_monitor_pkg::*;
#(
    parameter int DATA_WIDTH = 13,
    parameter int DEBOUNCE   = 4,
    parameter int SIGNED_CMP = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  thr_load_i,
    input  logic [DATA_WIDTH-1:0] thr_i,
    input  logic [2:0]            mode_i,
    input  logic                  sample_valid_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    output logic                  sample_ready_o,
    output logic                  result_valid_o,
    output logic                  result_o,
    output logic                  alarm_o,
    output logic                  alarm_rise_o,
    output logic                  alarm_fall_o
);

    localparam int                CNT_W      = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE - 1);
    localparam logic              DEB_SINGLE = (DEBOUNCE == 32'sd1);

    logic [DATA_WIDTH-1:0] thr_r;
    cmp_mode_e             mode_r;
    logic                  result_valid_r;
    logic                  result_r;
    mon_state_e            state_r;
    logic [CNT_W-1:0]      count_r;
    logic                  alarm_r;
    logic                  alarm_rise_r;
    logic                  alarm_fall_r;

    logic                  accept_s;
    logic                  cmp_res_s;

    // A threshold load stalls the sample source for that cycle.
    assign sample_ready_o = ~thr_load_i;
    assign accept_s       = sample_valid_i & ~thr_load_i;

    cmp_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_cmp_core (
        .a      (sample_i),
        .b      (thr_r),
        .mode   (mode_r),
        .result (cmp_res_s)
    );

    // Threshold and mode registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            thr_r  <= '0;
            mode_r <= CMP_GT;
        end else if (thr_load_i) begin
            thr_r  <= thr_i;
            mode_r <= cmp_mode_e'(mode_i);
        end else begin
            thr_r  <= thr_r;
            mode_r <= mode_r;
        end
    end

    // One-cycle result pipeline stage.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            result_valid_r <= 1'b0;
            result_r       <= 1'b0;
        end else begin
            result_valid_r <= accept_s;
            result_r       <= accept_s ? cmp_res_s : 1'b0;
        end
    end

    // Debounce FSM; a threshold load outranks a result arriving the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r      <= MON_IDLE;
            count_r      <= '0;
            alarm_r      <= 1'b0;
            alarm_rise_r <= 1'b0;
            alarm_fall_r <= 1'b0;
        end else begin
            alarm_rise_r <= 1'b0;
            alarm_fall_r <= 1'b0;
            alarm_r      <= state_alarm(state_r);
            if (thr_load_i) begin
                count_r <= '0;
                case (state_r)
                    MON_ARMING:    state_r <= MON_IDLE;
                    MON_DISARMING: state_r <= MON_ACTIVE;
                    default:       state_r <= state_r;
                endcase
            end else if (result_valid_r) begin
                case (state_r)
                    MON_IDLE: begin
                        if (result_r && DEB_SINGLE) begin
                            state_r      <= MON_ACTIVE;
                            count_r      <= '0;
                            alarm_r      <= 1'b1;
                            alarm_rise_r <= 1'b1;
                        end else if (result_r) begin
                            state_r <= MON_ARMING;
                            count_r <= CNT_W'(1);
                        end else begin
                            state_r <= MON_IDLE;
                            count_r <= '0;
                        end
                    end
                    MON_ARMING: begin
                        if (result_r && (count_r == CNT_LAST)) begin
                            state_r      <= MON_ACTIVE;
                            count_r      <= '0;
                            alarm_r      <= 1'b1;
                            alarm_rise_r <= 1'b1;
                        end else if (result_r) begin
                            state_r <= MON_ARMING;
                            count_r <= count_r + CNT_W'(1);
                        end else begin
                            state_r <= MON_IDLE;
                            count_r <= '0;
                        end
                    end
                    MON_ACTIVE: begin
                        if (!result_r && DEB_SINGLE) begin
                            state_r      <= MON_IDLE;
                            count_r      <= '0;
                            alarm_r      <= 1'b0;
                            alarm_fall_r <= 1'b1;
                        end else if (!result_r) begin
                            state_r <= MON_DISARMING;
                            count_r <= CNT_W'(1);
                        end else begin
                            state_r <= MON_ACTIVE;
                            count_r <= '0;
                        end
                    end
                    MON_DISARMING: begin
                        if (!result_r && (count_r == CNT_LAST)) begin
                            state_r      <= MON_IDLE;
                            count_r      <= '0;
                            alarm_r      <= 1'b0;
                            alarm_fall_r <= 1'b1;
                        end else if (!result_r) begin
                            state_r <= MON_DISARMING;
                            count_r <= count_r + CNT_W'(1);
                        end else begin
                            state_r <= MON_ACTIVE;
                            count_r <= '0;
                        end
                    end
                    default: begin
                        state_r <= MON_IDLE;
                        count_r <= '0;
                    end
                endcase
            end else begin
                state_r <= state_r;
                count_r <= count_r;
            end
        end
    end

    assign result_valid_o = result_valid_r;
    assign result_o       = result_r;
    assign alarm_o        = alarm_r;
    assign alarm_rise_o   = alarm_rise_r;
    assign alarm_fall_o   = alarm_fall_r;

endmodule

// File: tb/tb_comparator_threshold_monitor.sv
// Directed scoreboard bench: unsigned DW=13/DEBOUNCE=4 instance plus a signed
// DW=8/DEBOUNCE=1 instance sharing the clock.
module tb_comparator_threshold_monitor;
    import comparator_threshold_monitor_pkg::*;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst_n, thr_load, sample_valid;
    logic [12:0] thr, sample;
    logic [2:0]  mode;
    logic        sample_ready, result_valid, result, alarm, alarm_rise, alarm_fall;

    logic        s_rst_n, s_load, s_valid;
    logic [7:0]  s_thr, s_sample;
    logic [2:0]  s_mode;
    logic        s_ready, s_rv, s_res, s_alarm, s_rise, s_fall;

    int checks = 0;
    int errors = 0;

    logic        q[$];
    logic        rv_m = 1'b0;
    logic        res_m = 1'b0;
    logic        alarm_m = 1'b0;
    logic        rise_m = 1'b0;
    logic        fall_m = 1'b0;
    int          run_m = 0;
    logic [12:0] thr_m = 13'd0;
    logic [2:0]  mode_m = 3'd0;

    always #5 clk = ~clk;

    comparator_threshold_monitor #(.DATA_WIDTH(13), .DEBOUNCE(DEB), .SIGNED_CMP(0)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .thr_load_i(thr_load), .thr_i(thr), .mode_i(mode),
        .sample_valid_i(sample_valid), .sample_i(sample), .sample_ready_o(sample_ready),
        .result_valid_o(result_valid), .result_o(result), .alarm_o(alarm),
        .alarm_rise_o(alarm_rise), .alarm_fall_o(alarm_fall));

    comparator_threshold_monitor #(.DATA_WIDTH(8), .DEBOUNCE(1), .SIGNED_CMP(1)) u_sdut (
        .clk_i(clk), .rst_n_i(s_rst_n), .thr_load_i(s_load), .thr_i(s_thr), .mode_i(s_mode),
        .sample_valid_i(s_valid), .sample_i(s_sample), .sample_ready_o(s_ready),
        .result_valid_o(s_rv), .result_o(s_res), .alarm_o(s_alarm),
        .alarm_rise_o(s_rise), .alarm_fall_o(s_fall));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic ref_cmp(input logic [12:0] a, input logic [12:0] b, input logic [2:0] m);
        case (m)
            3'd0:    return a > b;
            3'd1:    return a >= b;
            3'd2:    return a < b;
            3'd3:    return a <= b;
            3'd4:    return a == b;
            3'd5:    return a != b;
            default: return 1'b0;
        endcase
    endfunction

    // One clock of the unsigned instance: drive, predict, clock, compare.
    task automatic step(input logic r, input logic ld, input logic [12:0] th, input logic [2:0] md,
                        input logic v, input logic [12:0] sm);
        logic acc;
        rst_n = r; thr_load = ld; thr = th; mode = md; sample_valid = v; sample = sm;
        #1;
        chk("sample_ready", sample_ready, !ld);
        acc = r && v && !ld;
        rise_m = 1'b0;
        fall_m = 1'b0;
        if (!r) begin
            q.delete();
            alarm_m = 1'b0; run_m = 0; thr_m = 13'd0; mode_m = 3'd0; rv_m = 1'b0;
        end else begin
            if (ld) begin
                run_m = 0;
            end else if (rv_m) begin
                if (res_m != alarm_m) begin
                    run_m++;
                    if (run_m == DEB) begin
                        alarm_m = !alarm_m;
                        run_m = 0;
                        rise_m = alarm_m;
                        fall_m = !alarm_m;
                    end
                end else begin
                    run_m = 0;
                end
            end
            if (acc) q.push_back(ref_cmp(sm, thr_m, mode_m));
            if (ld) begin
                thr_m = th; mode_m = md;
            end
            rv_m = acc;
        end
        @(posedge clk);
        #1;
        chk("result_valid", result_valid, rv_m);
        if (rv_m) begin
            if (q.size() > 0) begin
                res_m = q.pop_front();
                chk("result", result, res_m);
            end else begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end
        end else begin
            res_m = 1'b0;
            chk("result_idle", result, 1'b0);
        end
        chk("alarm", alarm, alarm_m);
        chk("alarm_rise", alarm_rise, rise_m);
        chk("alarm_fall", alarm_fall, fall_m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, thr_m, mode_m, 1'b0, 13'd0);
    endtask

    initial begin
        s_rst_n = 1'b0; s_load = 1'b0; s_valid = 1'b0; s_thr = 8'd0; s_sample = 8'd0; s_mode = 3'd0;

        // reset
        step(1'b0, 1'b0, 13'd0, 3'd0, 1'b0, 13'd0);
        step(1'b0, 1'b1, 13'd55, 3'd4, 1'b1, 13'd7);

        // GE threshold 100: 99, 100, 101
        step(1'b1, 1'b1, 13'd100, CMP_GE, 1'b0, 13'd0);
        step(1'b1, 1'b0, 13'd0, 3'd0, 1'b1, 13'd99);
        step(1'b1, 1'b0, 13'd0, 3'd0, 1'b1, 13'd100);
        step(1'b1, 1'b0, 13'd0, 3'd0, 1'b1, 13'd101);
        idle(2);

        // debounce: T T T F then T T T T
        step(1'b1, 1'b1, 13'd100, CMP_GE, 1'b0, 13'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 13'd0, 3'd0, 1'b1, 13'd200);
        step(1'b1, 1'b0, 13'd0, 3'd0, 1'b1, 13'd50);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 13'd0, 3'd0, 1'b1, 13'd200);
        idle(3);

        // active: three falses, load clears count, four more falses to fall
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 13'd0, 3'd0, 1'b1, 13'd50);
        idle(2);
        step(1'b1, 1'b1, 13'd100, CMP_GE, 1'b0, 13'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 13'd0, 3'd0, 1'b1, 13'd50);
        idle(2);
        step(1'b1, 1'b0, 13'd0, 3'd0, 1'b1, 13'd50);
        idle(3);

        // load together with a valid sample; sample held and accepted next cycle
        step(1'b1, 1'b1, 13'd10, CMP_LT, 1'b1, 13'd5);
        step(1'b1, 1'b0, 13'd0, 3'd0, 1'b1, 13'd5);
        idle(2);

        // every mode, including reserved, below/at/above threshold
        for (int m = 0; m < 8; m++) begin
            step(1'b1, 1'b1, 13'd100, 3'(m), 1'b0, 13'd0);
            for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 13'd0, 3'd0, 1'b1, 13'(99 + k));
            idle(1);
        end

        // boundary values at the top of the range
        step(1'b1, 1'b1, 13'h1FFF, CMP_EQ, 1'b0, 13'd0);
        step(1'b1, 1'b0, 13'd0, 3'd0, 1'b1, 13'h1FFF);
        step(1'b1, 1'b0, 13'd0, 3'd0, 1'b1, 13'h0000);
        idle(1);

        // reach ACTIVE, then reset with a result in flight
        step(1'b1, 1'b1, 13'd0, CMP_GE, 1'b0, 13'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 13'd0, 3'd0, 1'b1, 13'd3);
        idle(2);
        chk("alarm_active_before_reset", alarm, 1'b1);
        step(1'b1, 1'b0, 13'd0, 3'd0, 1'b1, 13'd9);
        step(1'b0, 1'b0, 13'd0, 3'd0, 1'b1, 13'd9);
        idle(2);

        // signed instance, DEBOUNCE=1: thr -16, GT; 0x05 -> 1, 0x80 -> 0
        idle(1);
        chk("s_reset_alarm", s_alarm, 1'b0);
        chk("s_reset_rv", s_rv, 1'b0);
        s_rst_n = 1'b1; s_load = 1'b1; s_thr = 8'hF0; s_mode = CMP_GT;
        idle(1);
        chk("s_ready_load", s_ready, 1'b0);
        s_load = 1'b0; s_valid = 1'b1; s_sample = 8'h05;
        idle(1);
        chk("s_rv_05", s_rv, 1'b1);
        chk("s_res_05", s_res, 1'b1);
        s_sample = 8'h80;
        idle(1);
        chk("s_rv_80", s_rv, 1'b1);
        chk("s_res_80", s_res, 1'b0);
        chk("s_alarm_rise", s_alarm, 1'b1);
        chk("s_rise_pulse", s_rise, 1'b1);
        s_valid = 1'b0;
        idle(1);
        chk("s_rv_done", s_rv, 1'b0);
        chk("s_alarm_fall", s_alarm, 1'b0);
        chk("s_fall_pulse", s_fall, 1'b1);
        chk("s_rise_cleared", s_rise, 1'b0);
        idle(1);
        chk("s_fall_cleared", s_fall, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
